// File: rtl/sign_mag_conv_pipe.sv
// Two-stage pipelined sign/magnitude <-> two's-complement converter with
// valid/ready flow control, overflow detection/saturation and a saturation-event counter.
module sign_mag_conv_pipe #(
  parameter int NO_BITS  = 10,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic                in_sign,
  input  logic [NO_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [NO_BITS-1:0]  out_data,
  output logic                out_ovf,
  input  logic                cnt_clr,
  output logic [CNT_BITS-1:0] sat_count
);

  localparam logic [NO_BITS-1:0] MAX_MAG   = {1'b1, {(NO_BITS-1){1'b0}}};
  localparam logic [NO_BITS-1:0] POS_CLAMP = {1'b0, {(NO_BITS-1){1'b1}}};

  logic                a_valid, a_mode, a_neg, a_ovf;
  logic [NO_BITS-1:0]  a_x;
  logic                b_valid, b_sign, b_ovf;
  logic [NO_BITS-1:0]  b_data;
  logic                a_ready, b_ready;
  logic                in_neg, in_ovf;
  logic [NO_BITS-1:0]  b_result;
  logic                b_result_sign;

  assign b_ready = !b_valid || out_ready;
  assign a_ready = !a_valid || b_ready;
  assign in_ready = a_ready;

  // Negation source differs by direction; overflow only exists for sign/magnitude input.
  always_comb begin
    in_neg = in_mode ? in_data[NO_BITS-1] : in_sign;
    in_ovf = 1'b0;
    if (!in_mode) begin
      if (in_sign) in_ovf = (in_data > MAX_MAG);
      else         in_ovf = (in_data >= MAX_MAG);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_mode  <= 1'b0;
      a_neg   <= 1'b0;
      a_ovf   <= 1'b0;
      a_x     <= '0;
    end else if (a_ready) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_mode <= in_mode;
        a_neg  <= in_neg;
        a_ovf  <= in_ovf;
        a_x    <= in_data ^ {NO_BITS{in_neg}};
      end
    end
  end

  // Increment completes the negation; saturation overrides the wrapped value.
  always_comb begin
    b_result = a_x + {{(NO_BITS-1){1'b0}}, a_neg};
    if (SATURATE && a_ovf)
      b_result = a_neg ? MAX_MAG : POS_CLAMP;
    b_result_sign = a_mode ? a_neg : b_result[NO_BITS-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_data  <= '0;
      b_sign  <= 1'b0;
      b_ovf   <= 1'b0;
    end else if (b_ready) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_data <= b_result;
        b_sign <= b_result_sign;
        b_ovf  <= a_ovf;
      end
    end
  end

  assign out_valid = b_valid;
  assign out_data  = b_data;
  assign out_sign  = b_sign;
  assign out_ovf   = b_ovf;

  // Clear takes priority over a coincident overflow delivery; count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (cnt_clr) begin
      sat_count <= '0;
    end else if (b_valid && out_ready && b_ovf && (sat_count != {CNT_BITS{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule
